// File: rtl/port_decoder_bank.sv
// port_decoder_bank: decodes a window of consecutive I/O port addresses into
// per-channel data registers. Each channel gets a one-cycle load pulse, and
// every channel can be read back onto in_port. Cycles in which both strobes
// are high are counted.
module port_decoder_bank #(
    parameter logic [15:0]        BASE_ADDR  = 16'h0001,
    parameter int unsigned        N_PORTS    = 4,
    parameter int unsigned        DATA_W     = 16,
    parameter logic [N_PORTS-1:0] PULSE_MASK = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      write_strobe,
    input  logic                      read_strobe,
    input  logic [15:0]               port_id,
    input  logic [DATA_W-1:0]         out_port,
    output logic [N_PORTS-1:0]        ld,
    output logic [N_PORTS*DATA_W-1:0] port_q,
    output logic [DATA_W-1:0]         in_port,
    output logic                      rd_hit,
    output logic [7:0]                err_cnt
);

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned CMP_W   = ADDR_W + 1;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned LAST_AD = 32'(BASE_ADDR) + N_PORTS - 1;

    // The channel count must be legal, and the top address must not pass 16'hFFFF.
    if (N_PORTS < 1 || N_PORTS > 16 || LAST_AD > 32'h0000_FFFF) begin : g_param_err
        $error("port_decoder_bank: illegal BASE_ADDR/N_PORTS combination");
    end

    logic [N_PORTS-1:0] hit_c;
    logic               hit_any_c;
    logic [DATA_W-1:0]  rd_data_c;
    logic               wr_c;
    logic               rd_c;
    logic               both_c;

    // Address decode. The compare is one bit wider than the address, so the window never wraps.
    always_comb begin
        hit_c = '0;
        for (int i = 0; i < int'(N_PORTS); i++) begin
            hit_c[i] = ({1'b0, port_id} == (CMP_W'(BASE_ADDR) + CMP_W'(i)));
        end
    end

    // Read-back mux. At most one hit bit is set, so OR-ing the masked channels selects that channel.
    always_comb begin
        rd_data_c = '0;
        for (int i = 0; i < int'(N_PORTS); i++) begin
            if (hit_c[i]) begin
                rd_data_c = rd_data_c | port_q[i*DATA_W +: DATA_W];
            end
        end
    end

    assign hit_any_c = |hit_c;
    assign wr_c      = write_strobe;
    assign rd_c      = read_strobe & ~write_strobe;
    assign both_c    = write_strobe & read_strobe;

    // Channel registers. A strobe-mode channel clears one edge after a write unless it is written again.
    always_ff @(posedge clk) begin
        if (reset) begin
            port_q <= '0;
        end else begin
            for (int i = 0; i < int'(N_PORTS); i++) begin
                if (wr_c && hit_c[i]) begin
                    port_q[i*DATA_W +: DATA_W] <= out_port;
                end else if (PULSE_MASK[i]) begin
                    port_q[i*DATA_W +: DATA_W] <= '0;
                end
            end
        end
    end

    // Load pulses. Each pulse lasts exactly the cycle after a decoded write.
    always_ff @(posedge clk) begin
        if (reset) begin
            ld <= '0;
        end else begin
            ld <= wr_c ? hit_c : '0;
        end
    end

    // Read-back. An unmapped read returns zero. A collision cycle leaves in_port unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_port <= '0;
            rd_hit  <= 1'b0;
        end else begin
            rd_hit <= rd_c & hit_any_c;
            if (rd_c) begin
                in_port <= hit_any_c ? rd_data_c : '0;
            end
        end
    end

    // Saturating count of cycles in which both strobes are high.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (both_c && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_port_decoder_bank.sv
// tb_port_decoder_bank: table-driven directed vectors followed by hand-written
// sequences for collision saturation, reset during operation and the top-of-map window.
module tb_port_decoder_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        write_strobe;
    logic        read_strobe;
    logic [15:0] port_id;
    logic [15:0] out_port;

    logic [3:0]  ld_a,      ld_b;
    logic [63:0] port_q_a,  port_q_b;
    logic [15:0] in_port_a, in_port_b;
    logic        rd_hit_a,  rd_hit_b;
    logic [7:0]  err_cnt_a, err_cnt_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    port_decoder_bank #(
        .BASE_ADDR (16'h0001),
        .N_PORTS   (4),
        .DATA_W    (16),
        .PULSE_MASK(4'b0001)
    ) dut_a (
        .clk         (clk),
        .reset       (reset),
        .write_strobe(write_strobe),
        .read_strobe (read_strobe),
        .port_id     (port_id),
        .out_port    (out_port),
        .ld          (ld_a),
        .port_q      (port_q_a),
        .in_port     (in_port_a),
        .rd_hit      (rd_hit_a),
        .err_cnt     (err_cnt_a)
    );

    port_decoder_bank #(
        .BASE_ADDR (16'hFFFC),
        .N_PORTS   (4),
        .DATA_W    (16),
        .PULSE_MASK(4'b0000)
    ) dut_b (
        .clk         (clk),
        .reset       (reset),
        .write_strobe(write_strobe),
        .read_strobe (read_strobe),
        .port_id     (port_id),
        .out_port    (out_port),
        .ld          (ld_b),
        .port_q      (port_q_b),
        .in_port     (in_port_b),
        .rd_hit      (rd_hit_b),
        .err_cnt     (err_cnt_b)
    );

    typedef struct {
        logic        we;
        logic        re;
        logic [15:0] id;
        logic [15:0] data;
        logic [3:0]  ld;
        logic [63:0] q;
        logic [15:0] din;
        logic        rdh;
        logic [7:0]  err;
    } vec_t;

    localparam int NV = 16;
    vec_t vt [NV];

    function automatic vec_t mk(input logic we, input logic re, input logic [15:0] id,
                                input logic [15:0] data, input logic [3:0] eld,
                                input logic [63:0] eq, input logic [15:0] edin,
                                input logic erdh, input logic [7:0] eerr);
        vec_t v;
        v.we = we; v.re = re; v.id = id; v.data = data;
        v.ld = eld; v.q = eq; v.din = edin; v.rdh = erdh; v.err = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, then move to just after the rising edge.
    task automatic cycle(input logic rst, input logic we, input logic re,
                         input logic [15:0] id, input logic [15:0] data);
        reset = rst; write_strobe = we; read_strobe = re; port_id = id; out_port = data;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [3:0] eld, input logic [63:0] eq,
                         input logic [15:0] edin, input logic erdh, input logic [7:0] eerr);
        chk({tag, ".ld"},      64'(ld_a),      64'(eld));
        chk({tag, ".port_q"},  port_q_a,       eq);
        chk({tag, ".in_port"}, 64'(in_port_a), 64'(edin));
        chk({tag, ".rd_hit"},  64'(rd_hit_a),  64'(erdh));
        chk({tag, ".err_cnt"}, 64'(err_cnt_a), 64'(eerr));
    endtask

    initial begin
        //            we    re    id        data      ld       port_q {ch3,ch2,ch1,ch0}  in_port   rdh   err
        vt[0]  = mk(1'b1, 1'b0, 16'h0003, 16'hBEEF, 4'b0100, 64'h0000_BEEF_0000_0000, 16'h0000, 1'b0, 8'd0);
        vt[1]  = mk(1'b0, 1'b0, 16'h0003, 16'h0000, 4'b0000, 64'h0000_BEEF_0000_0000, 16'h0000, 1'b0, 8'd0);
        vt[2]  = mk(1'b1, 1'b0, 16'h0005, 16'h1111, 4'b0000, 64'h0000_BEEF_0000_0000, 16'h0000, 1'b0, 8'd0);
        vt[3]  = mk(1'b1, 1'b0, 16'h0001, 16'h00A5, 4'b0001, 64'h0000_BEEF_0000_00A5, 16'h0000, 1'b0, 8'd0);
        vt[4]  = mk(1'b0, 1'b0, 16'h0001, 16'h0000, 4'b0000, 64'h0000_BEEF_0000_0000, 16'h0000, 1'b0, 8'd0);
        vt[5]  = mk(1'b1, 1'b0, 16'h0001, 16'h0001, 4'b0001, 64'h0000_BEEF_0000_0001, 16'h0000, 1'b0, 8'd0);
        vt[6]  = mk(1'b1, 1'b0, 16'h0001, 16'h0002, 4'b0001, 64'h0000_BEEF_0000_0002, 16'h0000, 1'b0, 8'd0);
        vt[7]  = mk(1'b0, 1'b0, 16'h0001, 16'h0000, 4'b0000, 64'h0000_BEEF_0000_0000, 16'h0000, 1'b0, 8'd0);
        vt[8]  = mk(1'b0, 1'b1, 16'h0003, 16'h0000, 4'b0000, 64'h0000_BEEF_0000_0000, 16'hBEEF, 1'b1, 8'd0);
        vt[9]  = mk(1'b0, 1'b0, 16'h0003, 16'h0000, 4'b0000, 64'h0000_BEEF_0000_0000, 16'hBEEF, 1'b0, 8'd0);
        vt[10] = mk(1'b0, 1'b1, 16'h0000, 16'h0000, 4'b0000, 64'h0000_BEEF_0000_0000, 16'h0000, 1'b0, 8'd0);
        vt[11] = mk(1'b1, 1'b0, 16'h0004, 16'hCAFE, 4'b1000, 64'hCAFE_BEEF_0000_0000, 16'h0000, 1'b0, 8'd0);
        vt[12] = mk(1'b0, 1'b1, 16'h0004, 16'h0000, 4'b0000, 64'hCAFE_BEEF_0000_0000, 16'hCAFE, 1'b1, 8'd0);
        vt[13] = mk(1'b1, 1'b0, 16'h0002, 16'h5555, 4'b0010, 64'hCAFE_BEEF_5555_0000, 16'hCAFE, 1'b0, 8'd0);
        vt[14] = mk(1'b0, 1'b1, 16'h0001, 16'h0000, 4'b0000, 64'hCAFE_BEEF_5555_0000, 16'h0000, 1'b1, 8'd0);
        vt[15] = mk(1'b1, 1'b1, 16'h0002, 16'h1234, 4'b0010, 64'hCAFE_BEEF_1234_0000, 16'h0000, 1'b0, 8'd1);

        // Reset held for two cycles while writes are strobed: nothing may be written or pulsed.
        #1;
        cycle(1'b1, 1'b1, 1'b0, 16'h0003, 16'hFFFF);
        chk_a("rst0", 4'b0000, 64'h0, 16'h0, 1'b0, 8'd0);
        cycle(1'b1, 1'b1, 1'b0, 16'h0001, 16'hFFFF);
        chk_a("rst1", 4'b0000, 64'h0, 16'h0, 1'b0, 8'd0);

        // Directed vectors.
        for (int i = 0; i < NV; i++) begin
            cycle(1'b0, vt[i].we, vt[i].re, vt[i].id, vt[i].data);
            chk_a($sformatf("vec%0d", i), vt[i].ld, vt[i].q, vt[i].din, vt[i].rdh, vt[i].err);
        end

        // Load in_port with BEEF, then issue 300 collision cycles. The counter must saturate and in_port must hold.
        cycle(1'b0, 1'b0, 1'b1, 16'h0003, 16'h0000);
        chk_a("pre_coll", 4'b0000, 64'hCAFE_BEEF_1234_0000, 16'hBEEF, 1'b1, 8'd1);
        for (int k = 1; k <= 300; k++) begin
            cycle(1'b0, 1'b1, 1'b1, 16'h0002, 16'h1234);
            chk($sformatf("coll%0d.err_cnt", k), 64'(err_cnt_a), 64'((k + 1 > 255) ? 255 : k + 1));
        end
        chk_a("coll_end", 4'b0010, 64'hCAFE_BEEF_1234_0000, 16'hBEEF, 1'b0, 8'hFF);

        // A pending ld is cleared by reset, and a read issued in the reset cycle is lost.
        cycle(1'b0, 1'b1, 1'b0, 16'h0003, 16'h7777);
        chk_a("pre_rst", 4'b0100, 64'hCAFE_7777_1234_0000, 16'hBEEF, 1'b0, 8'hFF);
        cycle(1'b1, 1'b0, 1'b1, 16'h0003, 16'h0000);
        chk_a("mid_rst", 4'b0000, 64'h0, 16'h0, 1'b0, 8'd0);
        chk("mid_rst.b_err", 64'(err_cnt_b), 64'd0);

        // Window at the top of the address map: FFFF hits ch3 and 0000 hits nothing.
        cycle(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0ABC);
        chk("top.b_ld", 64'(ld_b), 64'(4'b1000));
        chk("top.b_q",  port_q_b, 64'h0ABC_0000_0000_0000);
        cycle(1'b0, 1'b1, 1'b0, 16'h0000, 16'h1111);
        chk("wrap.b_ld", 64'(ld_b), 64'd0);
        chk("wrap.b_q",  port_q_b, 64'h0ABC_0000_0000_0000);
        cycle(1'b0, 1'b1, 1'b0, 16'hFFFB, 16'h2222);
        chk("below.b_ld", 64'(ld_b), 64'd0);
        cycle(1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000);
        chk("top_rd.b_in",  64'(in_port_b), 64'h0ABC);
        chk("top_rd.b_rdh", 64'(rd_hit_b),  64'd1);
        cycle(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        chk("wrap_rd.b_in",  64'(in_port_b), 64'h0);
        chk("wrap_rd.b_rdh", 64'(rd_hit_b),  64'd0);
        cycle(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("idle.b_ld", 64'(ld_b), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
